// File: rtl/uart_echo_fifo_pkg.sv
// Shared definitions for the UART echo engine: TX FSM encoding, ASCII constants
// and the lower-to-upper case helper used on the pop path.
package uart_echo_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_LC_A     = 8'h61;
  localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (b >= ASCII_LC_A && b <= ASCII_LC_Z) return b - ASCII_CASE_OFS;
    return b;
  endfunction

endpackage

// File: rtl/uart_echo_fifo_if.sv
// Byte-level link between the echo engine and the async receiver/transmitter pair.
interface uart_echo_fifo_if #(
  parameter int DATA_W = 8
);

  // rx_valid is a one-cycle strobe with no back-pressure: rx_data is only meaningful
  // while it is high. tx_start is a one-cycle request; tx_data stays stable until the
  // transmitter has raised and then dropped tx_busy (or the engine gives up waiting).
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              tx_busy;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;

  modport master (
    input  rx_valid, rx_data, tx_busy,
    output tx_start, tx_data
  );

  modport slave (
    output rx_valid, rx_data, tx_busy,
    input  tx_start, tx_data
  );

endinterface

// File: rtl/uart_echo_fifo_sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter so full and empty never alias.
module uart_echo_fifo_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // At full with a same-cycle pop, wr_ptr equals rd_ptr; the head is read before the write lands.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/uart_echo_fifo.sv
// Buffered UART echo: received bytes queue in a FIFO and are re-sent one at a time
// by a TX FSM that handshakes with the transmitter's busy flag.
module uart_echo_fifo
  import uart_echo_fifo_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               echo_en,
  input  logic               upper_en,
  input  logic               clr_err,
  uart_echo_fifo_if.master   bus,
  output logic [ADDR_W:0]    fifo_count,
  output logic               fifo_full,
  output logic               fifo_empty,
  output logic               overflow,
  output logic               timeout_err,
  output logic [7:0]         drop_count,
  output state_e             dbg_state
);

  localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              overflow_q, overflow_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        drop_q, drop_d;

  logic              push, pop, drop, busy_timeout;
  logic [DATA_W-1:0] head, xlat;

  uart_echo_fifo_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (bus.rx_data),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d      = state_q;
    busy_timeout = 1'b0;
    case (state_q)
      ST_IDLE:      if (pop) state_d = ST_START;
      ST_START:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (tmr_q == TMR_LAST) begin
          state_d      = ST_IDLE;
          busy_timeout = 1'b1;
        end
      end
      ST_WAIT_DONE: if (!bus.tx_busy) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; tx_start decodes straight from the state flop so reset kills it at once.
  always_comb begin
    bus.tx_start = (state_q == ST_START);
    pop          = (state_q == ST_IDLE) && echo_en && !fifo_empty;
    push         = bus.rx_valid && (!fifo_full || pop);
    drop         = bus.rx_valid && fifo_full && !pop;
  end

  // Datapath, timeout timer and sticky error bookkeeping.
  always_comb begin
    xlat = head;
    if (upper_en) xlat[7:0] = to_upper(head[7:0]);

    tmr_d     = (state_q == ST_WAIT_BUSY) ? tmr_q + TMR_W'(1) : '0;
    tx_data_d = pop ? xlat : tx_data_q;

    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    drop_d     = drop_q;
    if (clr_err) begin
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
      drop_d     = '0;
    end
    // A new event in the same cycle as clr_err wins over the clear.
    if (busy_timeout) timeout_d = 1'b1;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_err)              drop_d = 8'd1;
      else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q      <= '0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      drop_q     <= '0;
    end else begin
      tmr_q      <= tmr_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign overflow     = overflow_q;
  assign timeout_err  = timeout_q;
  assign drop_count   = drop_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo: transmitter model, expected-byte queue, directed scenarios.
module tb_uart_echo_fifo;
  import uart_echo_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic echo_en, upper_en, clr_err;
  logic [4:0] fifo_count;
  logic fifo_full, fifo_empty, overflow, timeout_err;
  logic [7:0] drop_count;
  state_e dbg_state;

  uart_echo_fifo_if #(.DATA_W(8)) bus ();

  uart_echo_fifo #(
    .DATA_W(8), .DEPTH(16), .ADDR_W(4), .BUSY_TIMEOUT(64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .echo_en     (echo_en),
    .upper_en    (upper_en),
    .clr_err     (clr_err),
    .bus         (bus),
    .fifo_count  (fifo_count),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .drop_count  (drop_count),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  int last_start_cyc = 0;
  int rx_cyc = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.tx_start) begin
      start_cnt++;
      last_start_cyc = cyc;
      if (exp_q.size() == 0) check("tx_unexpected_qsize", exp_q.size(), 1);
      else                   check("tx_data", bus.tx_data, exp_q.pop_front());
    end
  end

  // ---------------- transmitter model ----------------
  bit never_busy = 1'b0;
  int busy_len = 20;
  bit model_busy = 1'b0;

  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start && !never_busy) begin
        model_busy = 1'b1;
        @(negedge clk);
        bus.tx_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        bus.tx_busy = 1'b0;
        model_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rx_drive(input logic [7:0] b, input logic [7:0] exp, input bit expect_echo);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    rx_cyc = cyc;
    if (expect_echo) exp_q.push_back(exp);
  endtask

  task automatic rx_end();
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic [7:0] exp, input bit expect_echo);
    rx_drive(b, exp, expect_echo);
    rx_end();
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int max);
    int c0 = start_cnt;
    int n = 0;
    while (start_cnt == c0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(start_cnt != c0), 1);
  endtask

  task automatic wait_state(input string tag, input state_e st, input int max);
    int n = 0;
    while (dbg_state != st && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, dbg_state, st);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (!(dbg_state == ST_IDLE && fifo_empty && !bus.tx_busy && !model_busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < max), 1);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [7:0] lc_in  [4];
    logic [7:0] lc_out [4];
    logic [7:0] b;
    int c0;
    lc_in  = '{8'h61, 8'h7A, 8'h7B, 8'h40};
    lc_out = '{8'h41, 8'h5A, 8'h7B, 8'h40};

    echo_en = 1'b1;
    upper_en = 1'b0;
    clr_err = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_drops", drop_count, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // single byte: two-cycle latency, data held through the frame
    busy_len = 100;
    rx_byte(8'h41, 8'h41, 1'b1);
    wait_start("t1_start", 20);
    check("t1_latency", last_start_cyc - rx_cyc, 2);
    wait_state("t1_wait_done", ST_WAIT_DONE, 20);
    check("t1_tx_data_held", bus.tx_data, 8'h41);
    wait_idle("t1_idle", 300);
    check("t1_state_idle", dbg_state, ST_IDLE);

    // burst of 20: byte 0 is popped as byte 1 lands, bytes 1..16 fill the FIFO, 17..19 drop
    busy_len = 40;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 255));
      rx_drive(b, b, i < 17);
    end
    rx_end();
    check("t2_count", fifo_count, 16);
    check("t2_full", fifo_full, 1);
    check("t2_drops", drop_count, 3);
    check("t2_overflow", overflow, 1);
    wait_idle("t2_drain", 1200);
    check("t2_q_empty", exp_q.size(), 0);
    pulse_clr();
    check("t2_clr_overflow", overflow, 0);
    check("t2_clr_drops", drop_count, 0);

    // upper-case translation boundaries
    busy_len = 5;
    upper_en = 1'b1;
    for (int i = 0; i < 4; i++) rx_byte(lc_in[i], lc_out[i], 1'b1);
    wait_idle("t3_idle", 200);
    check("t3_q_empty", exp_q.size(), 0);
    upper_en = 1'b0;

    // transmitter never answers: exactly BUSY_TIMEOUT cycles in WAIT_BUSY
    never_busy = 1'b1;
    rx_byte(8'h55, 8'h55, 1'b1);
    wait_start("t4_start", 20);
    while (cyc < last_start_cyc + 64) @(negedge clk);
    check("t4_state_last", dbg_state, ST_WAIT_BUSY);
    check("t4_timeout_pre", timeout_err, 0);
    @(negedge clk);
    check("t4_state_abort", dbg_state, ST_IDLE);
    check("t4_timeout_set", timeout_err, 1);
    never_busy = 1'b0;
    rx_byte(8'h66, 8'h66, 1'b1);
    wait_idle("t4_next_idle", 200);
    check("t4_timeout_sticky", timeout_err, 1);
    pulse_clr();
    check("t4_timeout_clr", timeout_err, 0);

    // echo gated off: bytes buffered, nothing sent until re-enabled
    echo_en = 1'b0;
    c0 = start_cnt;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(0, 255));
      rx_byte(b, b, 1'b1);
    end
    repeat (10) @(negedge clk);
    check("t5_count", fifo_count, 5);
    check("t5_no_start", start_cnt - c0, 0);
    echo_en = 1'b1;
    wait_idle("t5_idle", 300);
    check("t5_q_empty", exp_q.size(), 0);

    // clr_err in the same cycle as a drop: the drop wins
    busy_len = 8;
    echo_en = 1'b0;
    for (int i = 0; i < 18; i++) begin
      b = 8'($urandom_range(0, 255));
      rx_byte(b, b, i < 16);
    end
    check("t7_drops_two", drop_count, 2);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'hEE;
    clr_err = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    clr_err = 1'b0;
    check("t7_drops_one", drop_count, 1);
    check("t7_overflow", overflow, 1);
    echo_en = 1'b1;
    wait_idle("t7_idle", 600);
    check("t7_q_empty", exp_q.size(), 0);
    pulse_clr();

    // asynchronous reset in WAIT_DONE with a byte still queued
    busy_len = 100;
    rx_byte(8'h33, 8'h33, 1'b1);
    wait_state("t6_wait_done", ST_WAIT_DONE, 30);
    rx_byte(8'h44, 8'h44, 1'b0);
    check("t6_count_pre", fifo_count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_state_async", dbg_state, ST_IDLE);
    check("t6_empty_async", fifo_empty, 1);
    check("t6_count_async", fifo_count, 0);
    check("t6_tx_start_async", bus.tx_start, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle("t6_model_idle", 200);
    busy_len = 5;
    rx_byte(8'h7E, 8'h7E, 1'b1);
    wait_start("t6_restart", 20);
    wait_idle("t6_idle", 200);
    check("t6_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
